node_dispatcher: RTL

- Per-node dispatcher that sits directly downstream of the task blocks and upstream of their shared op-word input.
- Each cycle it collects the ready bytes of up to `N_TASKS` tasks and forwards MCU commands onto the shared op bus.
- When no command is pending, it scans the tasks and issues an Execute op to the highest-priority ready task, with round-robin tie-break.
- It drives each op word for a fixed number of cycles and then returns the bus to idle, because tasks react only to changes of their op input.

---
 rtl/node_dispatcher_if.sv | 25 ++
 rtl/node_dispatcher.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/node_dispatcher_if.sv
// Task-ready bus, MCU command handshake and the shared op-word output of one node dispatcher.
// The master side is the environment; the slave side is the dispatcher itself.
interface node_dispatcher_if #(
   parameter int N_TASKS = 4
);
   logic [8*N_TASKS-1:0] task_bytes;
   logic [15:0]          mcu_op;
   logic                 mcu_op_valid;
   logic                 mcu_op_ready;
   logic [15:0]          op_out;
   logic [3:0]           grant_id;
   logic                 grant_valid;
   logic                 halted;
   logic                 busy;

   modport master (
      output task_bytes, mcu_op, mcu_op_valid,
      input  mcu_op_ready, op_out, grant_id, grant_valid, halted, busy
   );

   modport slave (
      input  task_bytes, mcu_op, mcu_op_valid,
      output mcu_op_ready, op_out, grant_id, grant_valid, halted, busy
   );
endinterface

// File: rtl/node_dispatcher.sv
// Forwards MCU commands (word on op_out 2 cycles after accept) and otherwise schedules Execute ops by priority with round-robin ties.
// One-entry command register: mcu_op_ready stays low from accept until the word is loaded onto op_out.
module node_dispatcher #(
   parameter int N_TASKS     = 4,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  logic CLK,
   input  logic RST,
   node_dispatcher_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DRIVE, GAP} state_t;

   localparam logic [3:0]  NT_M1    = 4'(N_TASKS - 1);
   localparam logic [15:0] HOLD_END = 16'(HOLD_CYCLES);
   localparam logic [15:0] GAP_END  = 16'(GAP_CYCLES);

   state_t      state;
   logic [15:0] cmd_dat;
   logic        cmd_full;
   logic        cmd_pend;
   logic        halted_q;
   logic [15:0] op_q;
   logic [3:0]  gid_q;
   logic        gvld_q;
   logic [3:0]  rr_ptr;
   logic [3:0]  scan_idx;
   logic [3:0]  scan_cnt;
   logic        best_vld;
   logic [3:0]  best_pri;
   logic [3:0]  best_id;
   logic [3:0]  best_idx;
   logic [15:0] cnt;

   logic [7:0]  cur_byte;
   logic        take;
   logic        cand_vld;
   logic [3:0]  cand_pri;
   logic [3:0]  cand_id;
   logic [3:0]  cand_idx;

   function automatic logic [3:0] wrap_inc(input logic [3:0] i);
      return (i == NT_M1) ? 4'd0 : i + 4'd1;
   endfunction

   always_comb begin
      cur_byte = 8'h00;
      for (int i = 0; i < N_TASKS; i++) begin
         if (scan_idx == 4'(i)) cur_byte = bus.task_bytes[8*i +: 8];
      end
   end

   // Strictly-greater replacement keeps the first visited task on a priority tie.
   assign take     = (cur_byte[3:0] != 4'h0) && (!best_vld || (cur_byte[7:4] > best_pri));
   assign cand_vld = best_vld | take;
   assign cand_pri = take ? cur_byte[7:4] : best_pri;
   assign cand_id  = take ? cur_byte[3:0] : best_id;
   assign cand_idx = take ? scan_idx      : best_idx;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         cmd_dat  <= 16'h0000;
         cmd_full <= 1'b0;
         cmd_pend <= 1'b0;
         halted_q <= 1'b0;
         op_q     <= 16'h0000;
         gid_q    <= 4'h0;
         gvld_q   <= 1'b0;
         rr_ptr   <= 4'h0;
         scan_idx <= 4'h0;
         scan_cnt <= 4'h0;
         best_vld <= 1'b0;
         best_pri <= 4'h0;
         best_id  <= 4'h0;
         best_idx <= 4'h0;
         cnt      <= 16'h0000;
      end else begin
         gvld_q <= 1'b0;
         // A freshly accepted word becomes visible to IDLE one cycle later.
         if (!cmd_full) begin
            if (bus.mcu_op_valid) begin
               cmd_full <= 1'b1;
               cmd_dat  <= bus.mcu_op;
            end
         end else begin
            cmd_pend <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (cmd_pend) begin
                  op_q     <= cmd_dat;
                  cmd_full <= 1'b0;
                  cmd_pend <= 1'b0;
                  if (cmd_dat[7:4] == 4'hC) halted_q <= 1'b1;
                  cnt      <= 16'd1;
                  state    <= DRIVE;
               end else if (!halted_q) begin
                  scan_idx <= rr_ptr;
                  scan_cnt <= 4'h0;
                  best_vld <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               best_vld <= cand_vld;
               best_pri <= cand_pri;
               best_id  <= cand_id;
               best_idx <= cand_idx;
               scan_idx <= wrap_inc(scan_idx);
               scan_cnt <= scan_cnt + 4'd1;
               if (scan_cnt == NT_M1) begin
                  if (cand_vld) begin
                     op_q   <= {4'h0, cand_id, 4'b0111, 4'h0};
                     gid_q  <= cand_id;
                     gvld_q <= 1'b1;
                     rr_ptr <= wrap_inc(cand_idx);
                     cnt    <= 16'd1;
                     state  <= DRIVE;
                  end else begin
                     state  <= IDLE;
                  end
               end
            end
            DRIVE: begin
               if (cnt == HOLD_END) begin
                  op_q  <= 16'h0000;
                  cnt   <= 16'd1;
                  state <= GAP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_END) state <= IDLE;
               else                cnt   <= cnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.op_out       = op_q;
   assign bus.grant_id     = gid_q;
   assign bus.grant_valid  = gvld_q;
   assign bus.halted       = halted_q;
   assign bus.busy         = (state != IDLE);
   assign bus.mcu_op_ready = !cmd_full;
endmodule
